mux_scan_scheduler: RTL

MUX_SCAN_SCHEDULER -- requirements
Module: mux_scan_scheduler

---
 rtl/mux_scan_scheduler.sv | 67 ++++++
 1 files changed

// File: rtl/mux_scan_scheduler.sv
// mux_scan_scheduler: round-robin scan of an 8-to-1 mux with a fixed dwell per channel.
// Samples the mux data bit on the last dwell cycle and reports it with its channel number.
module mux_scan_scheduler #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       mux_out,
    output logic [2:0] control,
    output logic       active,
    output logic [7:0] grant,
    output logic       sample,
    output logic [2:0] sample_ch,
    output logic       sample_valid
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t     state;
    logic [7:0] counter;
    logic [2:0] last;
    logic [2:0] pick;
    // Descending scan so the closest requester after last wins; offset 8 wraps to last itself.
    always_comb begin
        pick = last;
        for (int k = 7; k >= 0; k--)
            if (req[last + 3'(k + 1)]) pick = last + 3'(k + 1);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            control      <= 3'd0;
            active       <= 1'b0;
            grant        <= 8'd0;
            sample       <= 1'b0;
            sample_ch    <= 3'd0;
            sample_valid <= 1'b0;
            counter      <= 8'd0;
            last         <= 3'd7;
        end else begin
            sample_valid <= 1'b0;
            if (state == IDLE) begin
                if (en && req != 8'd0) begin
                    control <= pick;
                    grant   <= 8'd1 << pick;
                    counter <= 8'(DWELL - 1);
                    active  <= 1'b1;
                    state   <= HOLD;
                end
            end else if (!en) begin
                state  <= IDLE;
                active <= 1'b0;
                grant  <= 8'd0;
            end else if (counter != 8'd0) begin
                counter <= counter - 8'd1;
            end else begin
                sample       <= mux_out;
                sample_ch    <= control;
                sample_valid <= 1'b1;
                last         <= control;
                state        <= IDLE;
                active       <= 1'b0;
                grant        <= 8'd0;
            end
        end
    end
endmodule
